// File: rtl/seg_scan_pkg.sv
// Shared constants, frame bundle and helpers
// for the seven-segment scan scheduler.
package seg_scan_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SEL_W      = 3;
  localparam int DIGIT_W    = 4;
  localparam int DATA_W     = NUM_DIGITS * DIGIT_W;

  localparam logic [NUM_DIGITS-1:0] AN_OFF = 8'hFF;

  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [NUM_DIGITS-1:0] dp;
    logic [NUM_DIGITS-1:0] mask;
  } frame_t;

  function automatic logic [DIGIT_W-1:0] digit_of(
    input logic [DATA_W-1:0] data,
    input logic [SEL_W-1:0]  sel
  );
    return data[sel*DIGIT_W +: DIGIT_W];
  endfunction

  function automatic logic [SEL_W-1:0] lowest_set(
    input logic [NUM_DIGITS-1:0] m
  );
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (m[i]) r = SEL_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_scheduler_next_digit.sv
// Cyclic priority search for the next enabled
// digit after the current select.
module seg_next_digit
  import seg_scan_pkg::*;
(
  input  logic [NUM_DIGITS-1:0] mask_i,
  input  logic [SEL_W-1:0]      sel_i,
  output logic [SEL_W-1:0]      next_sel_o,
  output logic                  wrap_o
);

  logic [SEL_W-1:0] idx;

  // Scan far-to-near so the nearest enabled index wins.
  always_comb begin
    next_sel_o = '0;
    wrap_o     = 1'b1;
    idx        = '0;
    for (int i = NUM_DIGITS; i >= 1; i--) begin
      idx = sel_i + SEL_W'(i);
      if (mask_i[idx]) begin
        next_sel_o = idx;
        wrap_o     = (idx <= sel_i);
      end
    end
  end

endmodule

// File: rtl/seg_scan_scheduler.sv
// Digit scan timing, anti-ghost blanking, PWM
// and frame double-buffering for the display.
module seg_scan_scheduler
  import seg_scan_pkg::*;
#(
  parameter int TICK_DIV     = 250000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk_100MHz,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     frame_data,
  input  logic [NUM_DIGITS-1:0] frame_dp,
  input  logic [NUM_DIGITS-1:0] frame_en_mask,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  input  logic [3:0]            brightness,
  output logic [SEL_W-1:0]      select,
  output logic [DIGIT_W-1:0]    digit_val,
  output logic                  dp_n,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_start
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] SLOT_LAST =
    CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] BLANK_END =
    CW'(BLANK_CYCLES);

  logic [CW-1:0]         slot_q, slot_d;
  logic [3:0]            pwm_q, pwm_d;
  logic [3:0]            bright_q, bright_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  frame_t                act_q, act_d;
  frame_t                pend_q, pend_d;
  logic                  pvld_q, pvld_d;
  logic                  fs_q, fs_d;
  logic                  rdy_q, rdy_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [DIGIT_W-1:0]    dval_q, dval_d;
  logic                  dpn_q, dpn_d;

  logic                  slot_end;
  logic                  accept;
  logic                  lit;
  logic [SEL_W-1:0]      step_sel;
  logic                  wrap;

  seg_next_digit u_next (
    .mask_i     (act_q.mask),
    .sel_i      (sel_q),
    .next_sel_o (step_sel),
    .wrap_o     (wrap)
  );

  // Next state: counters, handshake, boundary swap,
  // and output values for the upcoming cycle.
  always_comb begin
    slot_end = (slot_q == SLOT_LAST);
    accept   = frame_valid && !pvld_q;
    slot_d   = slot_end ? '0 : slot_q + 1'b1;
    pwm_d    = slot_end ? '0 : pwm_q + 4'd1;
    bright_d = slot_end ? brightness : bright_q;
    sel_d    = sel_q;
    act_d    = act_q;
    pend_d   = pend_q;
    pvld_d   = pvld_q;
    fs_d     = 1'b0;
    if (accept) begin
      pend_d = '{data: frame_data,
                 dp:   frame_dp,
                 mask: frame_en_mask};
      pvld_d = 1'b1;
    end
    if (slot_end) begin
      fs_d  = wrap;
      sel_d = step_sel;
      if (wrap && pvld_q) begin
        act_d  = pend_q;
        pvld_d = 1'b0;
        sel_d  = lowest_set(pend_q.mask);
      end
    end
    rdy_d  = !pvld_d;
    lit    = (slot_d >= BLANK_END) &&
             act_d.mask[sel_d] &&
             (pwm_d <= bright_d);
    an_d   = lit ? ~(NUM_DIGITS'(1) << sel_d)
                 : AN_OFF;
    dval_d = digit_of(act_d.data, sel_d);
    dpn_d  = !act_d.dp[sel_d];
  end

  // State and registered outputs.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      slot_q   <= '0;
      pwm_q    <= '0;
      bright_q <= '0;
      sel_q    <= '0;
      act_q    <= '0;
      pend_q   <= '0;
      pvld_q   <= 1'b0;
      fs_q     <= 1'b0;
      rdy_q    <= 1'b1;
      an_q     <= AN_OFF;
      dval_q   <= '0;
      dpn_q    <= 1'b1;
    end else begin
      slot_q   <= slot_d;
      pwm_q    <= pwm_d;
      bright_q <= bright_d;
      sel_q    <= sel_d;
      act_q    <= act_d;
      pend_q   <= pend_d;
      pvld_q   <= pvld_d;
      fs_q     <= fs_d;
      rdy_q    <= rdy_d;
      an_q     <= an_d;
      dval_q   <= dval_d;
      dpn_q    <= dpn_d;
    end
  end

  assign frame_ready = rdy_q;
  assign select      = sel_q;
  assign digit_val   = dval_q;
  assign dp_n        = dpn_q;
  assign an          = an_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Scoreboard bench: stimulus queues per-slot
// expectations, a monitor checks each slot.
module tb_seg_scan_scheduler;

  localparam int TD = 20;
  localparam int BC = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] frame_data = '0;
  logic [7:0]  frame_dp = '0;
  logic [7:0]  frame_en_mask = '0;
  logic        frame_valid = 1'b0;
  logic        frame_ready;
  logic [3:0]  brightness = 4'd15;
  logic [2:0]  select;
  logic [3:0]  digit_val;
  logic        dp_n;
  logic [7:0]  an;
  logic        frame_start;

  seg_scan_scheduler #(
    .TICK_DIV     (TD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk_100MHz    (clk),
    .reset         (reset),
    .frame_data    (frame_data),
    .frame_dp      (frame_dp),
    .frame_en_mask (frame_en_mask),
    .frame_valid   (frame_valid),
    .frame_ready   (frame_ready),
    .brightness    (brightness),
    .select        (select),
    .digit_val     (digit_val),
    .dp_n          (dp_n),
    .an            (an),
    .frame_start   (frame_start)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    int         slot;
    logic [2:0] sel;
    logic [3:0] dval;
    logic       dpn;
    logic       fs;
    int         onc;
    int         onf;
  } rec_t;

  rec_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  task automatic push(input int s, input int sel,
                      input int dv, input bit dpn,
                      input bit fs, input int onc,
                      input int onf);
    rec_t r;
    r.slot = s;
    r.sel  = 3'(sel);
    r.dval = 4'(dv);
    r.dpn  = dpn;
    r.fs   = fs;
    r.onc  = onc;
    r.onf  = onf;
    q.push_back(r);
  endtask

  // Monitor: one queued record covers one slot.
  rec_t cur;
  bit   act = 0;
  int   k, oncnt, onfirst;
  bit   sel_bad, dv_bad, dp_bad, an_bad, fs_bad;
  always begin
    @(posedge clk);
    #1;
    if (reset) begin
      act = 0;
    end else begin
      k = cyc % TD;
      if (k == 0) begin
        act = 0;
        while (q.size() > 0 &&
               q[0].slot < cyc / TD) begin
          chk("missed_slot", q[0].slot, cyc / TD);
          void'(q.pop_front());
        end
        if (q.size() > 0 &&
            q[0].slot == cyc / TD) begin
          cur = q.pop_front();
          act = 1;
          oncnt = 0; onfirst = -1;
          sel_bad = 0; dv_bad = 0; dp_bad = 0;
          an_bad = 0; fs_bad = 0;
          chk($sformatf("fs_s%0d", cur.slot),
              frame_start, cur.fs);
        end
      end
      if (act) begin
        if (select !== cur.sel) sel_bad = 1;
        if (digit_val !== cur.dval) dv_bad = 1;
        if (dp_n !== cur.dpn) dp_bad = 1;
        if (k > 0 && frame_start !== 1'b0)
          fs_bad = 1;
        if (an !== 8'hFF) begin
          if (k < BC || an !== ~(8'h01 << cur.sel))
            an_bad = 1;
          if (oncnt == 0) onfirst = k;
          oncnt++;
        end
        if (k == TD - 1) begin
          chk($sformatf("sel_s%0d", cur.slot),
              sel_bad ? 32'hBAD : 32'(cur.sel),
              32'(cur.sel));
          chk($sformatf("dval_s%0d", cur.slot),
              dv_bad, 0);
          chk($sformatf("dpn_s%0d", cur.slot),
              dp_bad, 0);
          chk($sformatf("anshape_s%0d", cur.slot),
              an_bad, 0);
          chk($sformatf("fsextra_s%0d", cur.slot),
              fs_bad, 0);
          chk($sformatf("oncnt_s%0d", cur.slot),
              oncnt, cur.onc);
          chk($sformatf("onfirst_s%0d", cur.slot),
              onfirst, cur.onf);
          act = 0;
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    int g = 0;
    while (cyc != n) begin
      @(negedge clk);
      g++;
      if (g > 5000) begin
        n_fail++;
        $display("FAIL wait_cyc: got %0d want %0d",
                 cyc, n);
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic offer(input logic [31:0] d,
                       input logic [7:0] dp,
                       input logic [7:0] m);
    frame_data    = d;
    frame_dp      = dp;
    frame_en_mask = m;
    frame_valid   = 1'b1;
  endtask

  task automatic chk_reset_state(input string p);
    chk({p, "_an"}, an, 8'hFF);
    chk({p, "_sel"}, select, 0);
    chk({p, "_rdy"}, frame_ready, 1);
    chk({p, "_fs"}, frame_start, 0);
    chk({p, "_dval"}, digit_val, 0);
    chk({p, "_dpn"}, dp_n, 1);
  endtask

  int s3[8] = '{0, 2, 5, 7, 0, 2, 5, 7};
  int d3[8] = '{8, 10, 13, 15, 8, 10, 13, 15};

  initial begin
    @(posedge clk);
    @(negedge clk);
    chk_reset_state("rst");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int s = 1; s <= 5; s++)
      push(s, 0, 0, 1, 1, 0, -1);
    for (int i = 0; i < 8; i++)
      push(6 + i, i, i, !(i == 0 || i == 7),
           i == 0, 16, 4);

    wait_cyc(105);
    offer(32'h76543210, 8'h81, 8'hFF);
    wait_cyc(106);
    frame_valid = 1'b0;
    chk("rdy_after_accept", frame_ready, 0);
    wait_cyc(120);
    chk("rdy_after_swap", frame_ready, 1);

    for (int i = 0; i < 8; i++)
      push(14 + i, i, i, !(i == 0 || i == 7),
           i == 0, 16, 4);
    for (int j = 0; j < 8; j++)
      push(22 + j, s3[j], d3[j], s3[j] != 5,
           s3[j] == 0, 16, 4);

    wait_cyc(285);
    offer(32'hFEDCBA98, 8'h20, 8'hA5);
    wait_cyc(286);
    frame_valid = 1'b0;

    for (int i = 0; i < 8; i++)
      push(30 + i, i, 7 - i, 1, i == 0,
           (i < 2) ? 4 : 16, (i < 2) ? 16 : 4);

    wait_cyc(545);
    offer(32'h01234567, 8'h00, 8'hFF);
    wait_cyc(546);
    frame_valid = 1'b0;
    wait_cyc(585);
    brightness = 4'd3;
    wait_cyc(630);
    brightness = 4'd15;

    for (int i = 0; i < 5; i++)
      push(38 + i, i, 15 - i, 0, i == 0, 16, 4);

    wait_cyc(665);
    offer(32'h89ABCDEF, 8'hFF, 8'hFF);
    wait_cyc(666);
    frame_valid = 1'b0;
    chk("rdy_a_pending", frame_ready, 0);
    wait_cyc(670);
    offer(32'h11111111, 8'h00, 8'h0F);
    wait_cyc(700);
    chk("rdy_b_blocked", frame_ready, 0);
    wait_cyc(759);
    chk("rdy_b_boundary", frame_ready, 0);
    wait_cyc(760);
    chk("rdy_b_free", frame_ready, 1);
    wait_cyc(761);
    chk("rdy_b_taken", frame_ready, 0);
    frame_valid = 1'b0;

    wait_cyc(870);
    chk("pre_rst_sel", select, 5);
    chk("pre_rst_rdy", frame_ready, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_state("midrst");
    reset = 1'b0;
    for (int s = 1; s <= 3; s++)
      push(s, 0, 0, 1, 1, 0, -1);

    wait_cyc(81);
    chk("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
